// File: rtl/shift_register_v2.sv
// Parametrised shift/rotate/LFSR register with clock enable, shifted-out bit and zero flag.
// Latency: one cycle from the sampling clk edge to out/sout; zero is combinational from out.
// Backpressure: none; en=0 stalls the register and holds out and sout.
module shift_register_v2 #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [2:0]               ctrl,
    input  logic [$clog2(WIDTH)-1:0] amt,
    input  logic [WIDTH-1:0]         in,
    output logic [WIDTH-1:0]         out,
    output logic                     sout,
    output logic                     zero
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] MODE_CLEAR = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SRL   = 3'b010;
    localparam logic [2:0] MODE_SLL   = 3'b011;
    localparam logic [2:0] MODE_SRA   = 3'b100;
    localparam logic [2:0] MODE_ROR   = 3'b101;
    localparam logic [2:0] MODE_ROL   = 3'b110;
    localparam logic [2:0] MODE_LFSR  = 3'b111;

    logic [WIDTH-1:0]   srl_val;
    logic [WIDTH-1:0]   sll_val;
    logic [WIDTH-1:0]   sra_val;
    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] ror_dbl;
    logic [2*WIDTH-1:0] rol_dbl;
    logic [WIDTH-1:0]   lfsr_val;
    logic [SHW-1:0]     idx_right;
    logic [SHW-1:0]     idx_left;
    logic               fb;
    logic               amt_nz;
    logic [WIDTH-1:0]   out_nxt;
    logic               sout_nxt;

    assign srl_val = out >> amt;
    assign sll_val = out << amt;
    assign sra_val = $signed(out) >>> amt;

    // Rotates shift a doubled copy and pick the half that wrapped around.
    assign dbl     = {out, out};
    assign ror_dbl = dbl >> amt;
    assign rol_dbl = dbl << amt;

    // WIDTH is a power of two, so WIDTH-k is just -k modulo 2^SHW.
    assign idx_right = amt - SHW'(1);
    assign idx_left  = SHW'(0) - amt;
    assign amt_nz    = (amt != '0);

    assign fb       = ^(out & TAPS);
    assign lfsr_val = (out == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : {out[WIDTH-2:0], fb};

    always_comb begin
        out_nxt  = out;
        sout_nxt = sout;
        case (ctrl)
            MODE_CLEAR: begin
                out_nxt  = '0;
                sout_nxt = 1'b0;
            end
            MODE_LOAD: out_nxt = in;
            MODE_SRL: if (amt_nz) begin
                out_nxt  = srl_val;
                sout_nxt = out[idx_right];
            end
            MODE_SLL: if (amt_nz) begin
                out_nxt  = sll_val;
                sout_nxt = out[idx_left];
            end
            MODE_SRA: if (amt_nz) begin
                out_nxt  = sra_val;
                sout_nxt = out[idx_right];
            end
            MODE_ROR: if (amt_nz) begin
                out_nxt  = ror_dbl[WIDTH-1:0];
                sout_nxt = out[idx_right];
            end
            MODE_ROL: if (amt_nz) begin
                out_nxt  = rol_dbl[2*WIDTH-1:WIDTH];
                sout_nxt = out[idx_left];
            end
            MODE_LFSR: begin
                out_nxt  = lfsr_val;
                sout_nxt = out[WIDTH-1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out  <= '0;
            sout <= 1'b0;
        end else if (en) begin
            out  <= out_nxt;
            sout <= sout_nxt;
        end
    end

    assign zero = (out == '0);

endmodule

// File: tb/tb_shift_register_v2.sv
// Scoreboard bench for shift_register_v2 at WIDTH=8 and WIDTH=16.
module tb_shift_register_v2;

    localparam logic [2:0] CLR  = 3'b000;
    localparam logic [2:0] LD   = 3'b001;
    localparam logic [2:0] SRL  = 3'b010;
    localparam logic [2:0] SLL  = 3'b011;
    localparam logic [2:0] SRA  = 3'b100;
    localparam logic [2:0] ROR  = 3'b101;
    localparam logic [2:0] ROL  = 3'b110;
    localparam logic [2:0] LFSR = 3'b111;

    typedef struct packed {
        logic [15:0] o;
        logic        s;
        logic        z;
    } exp_t;

    logic        clk;
    logic        rst8, en8;
    logic [2:0]  ctrl8;
    logic [2:0]  amt8;
    logic [7:0]  in8, out8;
    logic        sout8, zero8;
    logic        rst16, en16;
    logic [2:0]  ctrl16;
    logic [3:0]  amt16;
    logic [15:0] in16, out16;
    logic        sout16, zero16;

    int n_pass  = 0;
    int n_total = 0;

    exp_t  q8[$];
    string n8[$];
    exp_t  q16[$];
    string n16[$];

    logic track8  = 1'b0;
    logic track16 = 1'b0;
    bit   seen8 [256];
    int   distinct8 = 0;
    int   zhit8     = 0;
    int   one16     = 0;
    int   zhit16    = 0;

    shift_register_v2 #(.WIDTH(8), .TAPS(8'hB8)) dut8 (
        .clk(clk), .rst(rst8), .en(en8), .ctrl(ctrl8), .amt(amt8),
        .in(in8), .out(out8), .sout(sout8), .zero(zero8)
    );

    shift_register_v2 #(.WIDTH(16), .TAPS(16'hB400)) dut16 (
        .clk(clk), .rst(rst16), .en(en16), .ctrl(ctrl16), .amt(amt16),
        .in(in16), .out(out16), .sout(sout16), .zero(zero16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic check(input string nm, input exp_t act, input exp_t req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got out=%h sout=%b zero=%b, expected out=%h sout=%b zero=%b",
                      nm, act.o, act.s, act.z, req.o, req.s, req.z);
    endtask

    task automatic check_int(input string nm, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    endtask

    task automatic push8(input logic [7:0] eo, input logic es, input string nm);
        exp_t e;
        e.o = {8'h00, eo};
        e.s = es;
        e.z = (eo == 8'h00);
        q8.push_back(e);
        n8.push_back(nm);
    endtask

    task automatic push16(input logic [15:0] eo, input logic es, input string nm);
        exp_t e;
        e.o = eo;
        e.s = es;
        e.z = (eo == 16'h0000);
        q16.push_back(e);
        n16.push_back(nm);
    endtask

    task automatic op8(input logic [2:0] c, input logic [2:0] a, input logic [7:0] d,
                       input logic [7:0] eo, input logic es, input string nm);
        en8 = 1'b1; ctrl8 = c; amt8 = a; in8 = d;
        @(posedge clk); #1;
        push8(eo, es, nm);
    endtask

    task automatic hold8(input logic [7:0] eo, input logic es, input string nm);
        en8 = 1'b0; ctrl8 = CLR; amt8 = 'x; in8 = 'x;
        @(posedge clk); #1;
        push8(eo, es, nm);
    endtask

    task automatic op16(input logic [2:0] c, input logic [3:0] a, input logic [15:0] d,
                        input logic do_chk, input logic [15:0] eo, input logic es, input string nm);
        en16 = 1'b1; ctrl16 = c; amt16 = a; in16 = d;
        @(posedge clk); #1;
        if (do_chk) push16(eo, es, nm);
    endtask

    function automatic logic [7:0] lfsr8_model(input logic [7:0] v);
        return (v == 8'h00) ? 8'h01 : {v[6:0], ^(v & 8'hB8)};
    endfunction

    // Monitors: one expected entry per cycle, compared at the falling edge.
    always @(negedge clk) begin
        exp_t  e;
        string nm;
        exp_t  a;
        if (q8.size() > 0) begin
            e  = q8.pop_front();
            nm = n8.pop_front();
            a.o = {8'h00, out8}; a.s = sout8; a.z = zero8;
            check(nm, a, e);
        end
        if (track8) begin
            if (zero8) zhit8++;
            if (!seen8[out8]) distinct8++;
            seen8[out8] = 1'b1;
        end
    end

    always @(negedge clk) begin
        exp_t  e;
        string nm;
        exp_t  a;
        if (q16.size() > 0) begin
            e  = q16.pop_front();
            nm = n16.pop_front();
            a.o = out16; a.s = sout16; a.z = zero16;
            check(nm, a, e);
        end
        if (track16) begin
            if (out16 == 16'h0001) one16++;
            if (zero16) zhit16++;
        end
    end

    initial begin
        logic [7:0] v;
        logic [7:0] ev;
        int         budget;

        rst8 = 1'b0; en8 = 1'b0; ctrl8 = CLR; amt8 = '0; in8 = '0;
        rst16 = 1'b0; en16 = 1'b0; ctrl16 = CLR; amt16 = '0; in16 = '0;
        push8(8'h00, 1'b0, "reset8");
        push16(16'h0000, 1'b0, "reset16");
        @(negedge clk); #1;
        rst8 = 1'b1; rst16 = 1'b1;

        op8(LD,  3'd0, 8'hB5, 8'hB5, 1'b0, "load_b5");
        op8(SRA, 3'd3, 8'h00, 8'hF6, 1'b1, "sra_k3");
        op8(LD,  3'd0, 8'hB5, 8'hB5, 1'b1, "reload_b5_a");
        op8(SRL, 3'd3, 8'h00, 8'h16, 1'b1, "srl_k3");
        op8(LD,  3'd0, 8'hB5, 8'hB5, 1'b1, "reload_b5_b");
        op8(SLL, 3'd4, 8'h00, 8'h50, 1'b1, "sll_k4");
        op8(LD,  3'd0, 8'h81, 8'h81, 1'b1, "load_81");
        op8(ROL, 3'd1, 8'h00, 8'h03, 1'b1, "rol_k1");
        op8(ROR, 3'd2, 8'h00, 8'hC0, 1'b1, "ror_k2");
        op8(ROR, 3'd0, 8'h00, 8'hC0, 1'b1, "ror_k0_a");
        op8(CLR, 3'd5, 8'h77, 8'h00, 1'b0, "clear_a");
        op8(LD,  3'd0, 8'hC0, 8'hC0, 1'b0, "load_c0");
        op8(ROR, 3'd0, 8'h00, 8'hC0, 1'b0, "ror_k0_b");
        op8(ROL, 3'd2, 8'h00, 8'h03, 1'b1, "rol_k2");

        op8(LD,   3'd0, 8'h01, 8'h01, 1'b1, "load_01");
        op8(LFSR, 3'd5, 8'h00, 8'h02, 1'b0, "lfsr_step1");
        track8 = 1'b1;
        v = 8'h02;
        for (int i = 2; i <= 254; i++) begin
            ev = lfsr8_model(v);
            op8(LFSR, 3'd0, 8'h00, ev, v[7], "lfsr_walk");
            v = ev;
        end
        op8(LFSR, 3'd0, 8'h00, 8'h01, 1'b1, "lfsr_step255");
        @(negedge clk); #1;
        track8 = 1'b0;
        check_int("lfsr8_distinct", distinct8, 255);
        check_int("lfsr8_zero_seen", zhit8, 0);

        op8(CLR,  3'd0, 8'h00, 8'h00, 1'b0, "clear_b");
        op8(LFSR, 3'd0, 8'h00, 8'h01, 1'b0, "lfsr_escape");

        op8(LD,   3'd0, 8'h80, 8'h80, 1'b0, "load_80");
        op8(LFSR, 3'd0, 8'h00, 8'h01, 1'b1, "lfsr_from_80");
        op8(LD,   3'd0, 8'h5A, 8'h5A, 1'b1, "load_5a");
        for (int i = 0; i < 5; i++) hold8(8'h5A, 1'b1, "hold_en0");
        op8(CLR,  3'd0, 8'h00, 8'h00, 1'b0, "clear_after_hold");

        op8(LD, 3'd0, 8'hFF, 8'hFF, 1'b0, "load_ff");
        en8 = 1'b0;
        @(posedge clk); #2;
        rst8 = 1'b0;
        push8(8'h00, 1'b0, "async_reset");
        @(negedge clk); #1;
        rst8 = 1'b1;
        op8(LD, 3'd0, 8'h3C, 8'h3C, 1'b0, "load_after_reset");
        en8 = 1'b0;

        op16(LD,  4'd0,  16'h8001, 1'b1, 16'h8001, 1'b0, "w16_load_8001");
        op16(SRA, 4'd15, 16'h0000, 1'b1, 16'hFFFF, 1'b0, "w16_sra_k15");
        op16(LD,  4'd0,  16'h0001, 1'b1, 16'h0001, 1'b0, "w16_load_0001");
        op16(LFSR, 4'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, "w16_lfsr");
        track16 = 1'b1;
        for (int i = 2; i <= 65534; i++)
            op16(LFSR, 4'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, "w16_lfsr");
        op16(LFSR, 4'd0, 16'h0000, 1'b1, 16'h0001, 1'b1, "w16_lfsr_period");
        @(negedge clk); #1;
        track16 = 1'b0;
        en16 = 1'b0;
        check_int("lfsr16_returns_to_1", one16, 1);
        check_int("lfsr16_zero_seen", zhit16, 0);

        budget = 0;
        while ((q8.size() > 0 || q16.size() > 0) && budget < 20) begin
            @(negedge clk); #1;
            budget++;
        end
        check_int("scoreboard_drained", q8.size() + q16.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/shift_register_v2.md
Name: shift_register_v2

Overview:
- Parametrised successor to the fixed-width 3-bit-mode shift register.
- One registered WIDTH-bit word driven by an 8-way mode select:
  - clear and load
  - logical and arithmetic shifts and rotates by a variable amount (barrel, single cycle)
  - Fibonacci LFSR step with parametrised taps
- Adds a clock enable, a registered shifted-out bit and a zero flag.
- Instantiated under top in place of the fixed shift register.

Parameters:
- WIDTH, 8, data width; power of two, 2..64.
- TAPS, 8'hB8, WIDTH-bit LFSR tap mask; bit i set means out[i] feeds back. The default is x^8+x^6+x^5+x^4+1, maximal length for WIDTH=8.
- SHW, $clog2(WIDTH), shift-amount width (localparam, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  operation enable; 0 holds all state.
- ctrl  in  3  mode select.
- amt  in  SHW  shift/rotate amount k, 0..WIDTH-1.
- in  in  WIDTH  load data.
- out  out  WIDTH  register contents.
- sout  out  1  last bit shifted/rotated out.
- zero  out  1  high when out == 0.

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-operation): out=0, sout=0. zero=1 follows from out.
- All updates happen on a rising clk edge with rst=1 and en=1. With en=0, out and sout hold regardless of ctrl, amt and in.
- Latency: one cycle. A result is visible on out the cycle after the edge that sampled ctrl.
- ctrl decode (k = amt):
  - 000 CLEAR: out=0, sout=0.
  - 001 LOAD: out=in; sout holds.
  - 010 SRL: out=out>>k, zero-filled from the top.
  - 011 SLL: out=out<<k, zero-filled from the bottom.
  - 100 SRA: out=out>>>k, top filled with the old out[WIDTH-1].
  - 101 ROR: out rotated right by k.
  - 110 ROL: out rotated left by k.
  - 111 LFSR:
    - fb = XOR-reduce(out & TAPS); out={out[WIDTH-2:0], fb}.
    - If out==0 before the step, next out=1 (lockup escape).
    - amt ignored; sout=old out[WIDTH-1].
- sout for SRL/SRA/ROR with k>0: old out[k-1]. For SLL/ROL with k>0: old out[WIDTH-k].
- k=0 on any shift/rotate: out unchanged and sout holds. This is not an error.
- Widths: all arithmetic is WIDTH bits; no carry out except via sout. Since WIDTH is a power of two, amt covers exactly 0..WIDTH-1 and no out-of-range case exists.
- zero is combinational from the registered out (no extra latency).
- Ops are single-cycle and independent; back-to-back modes on consecutive cycles must each take effect.
- X on ctrl/amt/in while en=0 must not disturb state.

Test Plan:
- Reset:
  - rst low at start -> out=0x00, sout=0, zero=1.
  - rst low asynchronously mid-cycle after LOAD 0xFF -> out=0x00 immediately, without waiting for a clk edge.
- Shifts (from LOAD 0xB5):
  - SRA k=3 -> out=0xF6, sout=1.
  - Reload 0xB5, SRL k=3 -> out=0x16, sout=1.
  - Reload 0xB5, SLL k=4 -> out=0x50, sout=1.
- Rotates:
  - LOAD 0x81, ROL k=1 -> out=0x03, sout=1.
  - Then ROR k=2 -> out=0xC0, sout=1.
  - Then ROR k=0 -> out=0xC0, sout unchanged.
- LFSR:
  - LOAD 0x01, LFSR x1 -> out=0x02.
  - Continue stepping: out returns to 0x01 after exactly 255 total steps, zero never asserts, all 255 nonzero values are seen once.
  - CLEAR then LFSR -> out=0x01.
- Enable/hold:
  - LOAD 0x5A, then en=0 with ctrl=CLEAR for 5 cycles -> out stays 0x5A, sout unchanged.
  - Then en=1 with CLEAR -> out=0x00, zero=1.
- Parametrisation: WIDTH=16, TAPS=16'hB400.
  - LOAD 0x8001, SRA k=15 -> out=0xFFFF, sout=0.
  - LFSR from 0x0001 -> period 65535.
